// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle core: opcodes, ALU control codes,
// datapath mux selects and the control FSM state type.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASSB = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_NOTB  = 3'd5;
  localparam logic [2:0] ALU_CMPEQ = 3'd6;
  localparam logic [2:0] ALU_PASSA = 3'd7;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog counting consecutive cycles spent waiting on the memory handshake.
// expired_o rises in the TIMEOUT-th waiting cycle; TIMEOUT=0 never expires.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of earlier waiting cycles, so TIMEOUT-1 marks the last one allowed
  assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit core: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, handshakes with shared memory and counts retired instructions.
module multicycle_ctrl import cpu_pkg::*; #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_ctrl,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             bus_err_q, bus_err_d;
  logic             retire;
  logic             in_mem;
  logic             wd_expired;
  logic             unused_instr;

  assign unused_instr = ^instr[11:0];
  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!in_mem || mem_ready),
    .enable_i  (in_mem),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bus_err_d  = bus_err_q;
    retire     = 1'b0;
    alu_ctrl   = ALU_PASSB;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wd_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH only needs the compare
        op_d      = instr[15:12];
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        case (instr[15:12])
          OP_NOP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_HALT: state_d = S_HALT;
          default: begin
            if (is_illegal(instr[15:12])) begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_EXEC;
            end
          end
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (op_q == OP_LW || op_q == OP_SW) begin
          alu_src_b = SRCB_IMM;
          alu_ctrl  = ALU_ADD;
          state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        end else begin
          alu_src_b = SRCB_REG;
          alu_ctrl  = (op_q == OP_MOV) ? ALU_PASSB : op_q[2:0];
          state_d   = S_WB;
        end
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_WB;
        end else if (wd_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (wd_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_ctrl  = ALU_CMPEQ;
        pc_write  = alu_zero;
        pc_src    = PCSRC_ALUOUT;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign retired_d = retire ? retired_q + 1'b1 : retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      retired_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign retired   = retired_q;
  assign bus_err   = bus_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction into
// its expected per-cycle control outputs, which are replayed and compared cycle by cycle.
module tb_multicycle_ctrl;
  import cpu_pkg::*;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      instr;
  logic             alu_zero, mem_ready;
  logic [2:0]       alu_ctrl;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0]       pc_src;
  logic             reg_write, mem_to_reg;
  logic [CNT_W-1:0] retired;
  logic             halted, illegal, bus_err;
  state_t           state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .retired(retired), .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [2:0]       alu_ctrl;
    logic             src_a;
    logic [1:0]       src_b;
    logic             mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0]       pc_src;
    logic             reg_write, mem_to_reg, halted, illegal, bus_err;
    logic [CNT_W-1:0] retired;
  } obs_t;

  typedef struct packed {
    logic [15:0] ins;
    logic        rdy;
    logic        zero;
  } drv_t;

  obs_t exp_q[$];
  drv_t drv_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [CNT_W-1:0] ret_m;
  logic berr_m;

  function automatic obs_t act_obs();
    return {alu_ctrl, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write, pc_write,
            pc_src, reg_write, mem_to_reg, halted, illegal, bus_err, retired};
  endfunction

  function automatic obs_t base_obs();
    obs_t o;
    o = '0;
    o.retired = ret_m;
    o.bus_err = berr_m;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t a, input obs_t e);
    total++;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, a, e);
    end
  endtask

  task automatic push(input obs_t o, input logic [15:0] ins, input logic rdy, input logic zero);
    drv_t d;
    d.ins = ins; d.rdy = rdy; d.zero = zero;
    exp_q.push_back(o);
    drv_q.push_back(d);
  endtask

  // Cycles where mem_ready/alu_zero must not matter get random values
  task automatic push_any(input obs_t o, input logic [15:0] ins);
    push(o, ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic mem_phase(input obs_t o, input obs_t done_o, input int w,
                           input logic [15:0] ins, output bit ok);
    for (int i = 0; i <= w && i < TMO; i++) begin
      if (i == w) push(done_o, ins, 1'b1, 1'($urandom_range(0, 1)));
      else        push(o, ins, 1'b0, 1'($urandom_range(0, 1)));
    end
    ok = (w < TMO);
    if (!ok) berr_m = 1'b1;
  endtask

  task automatic gen_instr(input logic [15:0] ins, input int wf, input int wm, input logic zero);
    logic [3:0] op;
    obs_t o, d;
    bit ok;
    op = ins[15:12];
    o = base_obs(); o.alu_ctrl = 3'd1; o.src_b = 2'd1; o.mem_read = 1'b1;
    d = o; d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_phase(o, d, wf, ins, ok);
    if (!ok) return;
    o = base_obs(); o.alu_ctrl = 3'd1; o.src_b = 2'd2; o.illegal = (op >= 4'hB && op <= 4'hE);
    push_any(o, ins);
    case (op)
      4'h0: ret_m++;
      4'h7: begin
        o = base_obs(); o.src_a = 1'b1; o.alu_ctrl = 3'd6; o.pc_write = zero; o.pc_src = 2'd1;
        push(o, ins, 1'($urandom_range(0, 1)), zero);
        ret_m++;
      end
      4'hA: begin
        o = base_obs(); o.pc_write = 1'b1; o.pc_src = 2'd2;
        push_any(o, ins);
        ret_m++;
      end
      4'h8, 4'h9: begin
        o = base_obs(); o.src_a = 1'b1; o.src_b = 2'd2; o.alu_ctrl = 3'd1;
        push_any(o, ins);
        o = base_obs(); o.iord = 1'b1;
        if (op == 4'h8) o.mem_read = 1'b1; else o.mem_write = 1'b1;
        mem_phase(o, o, wm, ins, ok);
        if (!ok) return;
        if (op == 4'h8) begin
          o = base_obs(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          push_any(o, ins);
        end
        ret_m++;
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        o = base_obs(); o.src_a = 1'b1; o.src_b = 2'd0;
        o.alu_ctrl = (op == 4'h6) ? 3'd0 : op[2:0];
        push_any(o, ins);
        o = base_obs(); o.reg_write = 1'b1;
        push_any(o, ins);
        ret_m++;
      end
      default: ;
    endcase
  endtask

  task automatic push_halt(input int n);
    obs_t o;
    o = base_obs(); o.halted = 1'b1;
    repeat (n) push_any(o, 16'($urandom));
  endtask

  // Entered and left at 1 time unit after a rising edge
  task automatic play(input string tag, input int n);
    drv_t d;
    obs_t e;
    int   cnt;
    cnt = 0;
    while (exp_q.size() > 0 && (n <= 0 || cnt < n)) begin
      d = drv_q.pop_front();
      e = exp_q.pop_front();
      instr = d.ins; mem_ready = d.rdy; alu_zero = d.zero;
      @(negedge clk);
      check(tag, act_obs(), e);
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_outputs", act_obs(), obs_t'(0));
    total++;
    assert (state_dbg === S_IDLE) else begin
      bad++;
      $error("FAIL reset_state observed=%0d expected=%0d", state_dbg, S_IDLE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ret_m = '0; berr_m = 1'b0;
    exp_q.delete(); drv_q.delete();
    push_any(base_obs(), 16'h0000);
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b0; instr = '0; mem_ready = 1'b0; alu_zero = 1'b0;
    ret_m = '0; berr_m = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    gen_instr(16'h1240, 0, 0, 1'b0);
    play("add", 0);
    total++;
    assert (retired === 4'd1) else begin
      bad++;
      $error("FAIL add_retired observed=%0d expected=1", retired);
    end

    gen_instr(16'h7123, 0, 0, 1'b1);
    gen_instr(16'h7456, 0, 0, 1'b0);
    play("beq", 0);

    gen_instr(16'h8203, 0, 3, 1'b0);
    gen_instr(16'h9041, 2, 1, 1'b0);
    play("lw_sw_wait", 0);

    gen_instr(16'hC000, 0, 0, 1'b0);
    gen_instr(16'h0000, 1, 0, 1'b0);
    gen_instr(16'hA7FF, 0, 0, 1'b0);
    play("illegal_nop_j", 0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      gen_instr({op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end
    play("random", 0);

    gen_instr(16'h8000, 0, 3, 1'b0);
    play("mid_memrd", 4);
    mem_ready = 1'b0;
    #1;
    total++;
    assert (mem_read === 1'b1) else begin
      bad++;
      $error("FAIL memrd_before_rst observed=%b expected=1", mem_read);
    end
    do_reset();
    gen_instr(16'h2abc, 0, 0, 1'b0);
    play("after_rst", 0);

    gen_instr(16'hF000, 1, 0, 1'b0);
    push_halt(100);
    play("halt", 0);

    do_reset();
    gen_instr(16'h1000, 9, 0, 1'b0);
    push_halt(8);
    play("timeout", 0);

    do_reset();
    gen_instr(16'h9000, 0, 5, 1'b0);
    push_halt(4);
    play("memwr_timeout", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
